// File: rtl/rx_bit_sequencer.sv
// -----------------------------------------------------------------------------
// rx_bit_sequencer
//   Receive-side bit-timing controller. Every data-line edge reported by
//   edge_det realigns a per-bit clock counter, and the block strobes the RX
//   shift register once per bit at a fixed sample point. It also flags byte
//   boundaries, a clean end-of-packet, and framing or bit-stuffing errors.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   enable     in   arms the receiver; dropping it aborts the packet
//   edge_pulse in   one-cycle pulse on a data-line transition
//   eop        in   level, line currently in EOP state
//   shift_en   out  one-cycle sample strobe to the shift register
//   byte_done  out  one-cycle pulse coincident with the last shift of a byte
//   bit_index  out  index of the next bit to be shifted
//   rcving     out  packet in progress (ACTIVE or EOP_WAIT)
//   rx_error   out  framing / stuffing error flag (ERROR state)
// -----------------------------------------------------------------------------
module rx_bit_sequencer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int MAX_RUN       = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             edge_pulse,
  input  logic                             eop,
  output logic                             shift_en,
  output logic                             byte_done,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_index,
  output logic                             rcving,
  output logic                             rx_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(BITS_PER_BYTE);
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_BYTE - 1);

  localparam logic [RUN_W-1:0] RUN_ZERO = RUN_W'(0);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_EOP_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
  logic [IDX_W-1:0] bit_index_q, bit_index_d;
  logic [RUN_W-1:0] run_cnt_q,   run_cnt_d;

  logic sample_hit;

  assign sample_hit = (clk_cnt_q == SAMPLE_CNT);
  assign bit_index  = bit_index_q;

  // State and counter registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= CNT_ZERO;
      bit_index_q <= IDX_ZERO;
      run_cnt_q   <= RUN_ZERO;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_index_q <= bit_index_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  // Next-state and counter update, in the ACTIVE priority order.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_index_d = bit_index_q;
    run_cnt_d   = run_cnt_q;
    case (state_q)
      S_IDLE: begin
        // Counters are held at zero so a new packet always starts clean.
        clk_cnt_d   = CNT_ZERO;
        bit_index_d = IDX_ZERO;
        run_cnt_d   = RUN_ZERO;
        if (enable && edge_pulse) begin
          state_d = S_ACTIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (edge_pulse) begin
          // Resync wins over a coincident sample point; the bit is
          // re-sampled SAMPLE_POINT+1 cycles later.
          clk_cnt_d = CNT_ZERO;
          run_cnt_d = RUN_ZERO;
        end else if (sample_hit && eop) begin
          if (bit_index_q == IDX_ZERO) begin
            state_d = S_EOP_WAIT;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d = CNT_ZERO;
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_ONE;
          end
          if (sample_hit) begin
            // This is a shift cycle; MAX_RUN samples without an edge means
            // the transmitter failed to stuff a bit.
            if (run_cnt_q == RUN_LAST) begin
              state_d   = S_ERROR;
              run_cnt_d = RUN_MAX;
            end else begin
              run_cnt_d = run_cnt_q + RUN_ONE;
              if (bit_index_q == IDX_LAST) begin
                bit_index_d = IDX_ZERO;
              end else begin
                bit_index_d = bit_index_q + IDX_ONE;
              end
            end
          end else begin
            run_cnt_d = run_cnt_q;
          end
        end
      end
      S_EOP_WAIT: begin
        if (!eop || !enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_EOP_WAIT;
        end
      end
      S_ERROR: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERROR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state (plus the qualifying line inputs).
  always_comb begin
    shift_en  = 1'b0;
    byte_done = 1'b0;
    rcving    = 1'b0;
    rx_error  = 1'b0;
    case (state_q)
      S_ACTIVE: begin
        rcving = 1'b1;
        if (sample_hit && !eop && !edge_pulse) begin
          shift_en  = 1'b1;
          byte_done = (bit_index_q == IDX_LAST);
        end else begin
          shift_en  = 1'b0;
          byte_done = 1'b0;
        end
      end
      S_EOP_WAIT: begin
        rcving = 1'b1;
      end
      S_ERROR: begin
        rx_error = 1'b1;
      end
      default: begin
        rcving   = 1'b0;
        rx_error = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_bit_sequencer.sv
module tb_rx_bit_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       edge_pulse = 1'b0;
  logic       eop = 1'b0;
  logic       shift_en;
  logic       byte_done;
  logic [2:0] bit_index;
  logic       rcving;
  logic       rx_error;

  int errors = 0;
  int checks = 0;

  // Values sampled mid-cycle by cyc()
  logic       s_shift, s_bd, s_rcv, s_err;
  logic [2:0] s_idx;

  always #5 clk = ~clk;

  rx_bit_sequencer #(
    .CLKS_PER_BIT (8),
    .SAMPLE_POINT (3),
    .BITS_PER_BYTE(8),
    .MAX_RUN      (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .edge_pulse(edge_pulse),
    .eop       (eop),
    .shift_en  (shift_en),
    .byte_done (byte_done),
    .bit_index (bit_index),
    .rcving    (rcving),
    .rx_error  (rx_error)
  );

  // One clock cycle: drive inputs, sample outputs on the falling edge,
  // return just after the next rising edge.
  task automatic cyc(input logic e, input logic p, input logic o);
    enable     = e;
    edge_pulse = p;
    eop        = o;
    @(negedge clk);
    s_shift = shift_en;
    s_bd    = byte_done;
    s_rcv   = rcving;
    s_err   = rx_error;
    s_idx   = bit_index;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [6:0] got;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, i[0] ? 1'b0 : 1'b1, 1'b0);
      got = {s_shift, s_bd, s_rcv, s_err, s_idx};
      checks++;
      if (got !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, got, 7'd0);
      end
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    got = {s_shift, s_bd, s_rcv, s_err, s_idx};
    checks++;
    if (got !== 7'd0) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", got, 7'd0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, i[0], 1'b0);
      checks++;
      if ({s_shift, s_rcv} !== 2'b00) begin
        errors++;
        $display("FAIL reset_disabled_edges cyc=%0d got shift,rcv=%b exp=00", i, {s_shift, s_rcv});
      end
    end
  endtask

  task automatic test_single_byte;
    logic p, o;
    logic [3:0] exp_v;
    for (int c = 0; c <= 85; c++) begin
      p = (c >= 10 && c <= 66 && ((c - 10) % 8) == 0) || (c == 80);
      o = (c >= 76 && c <= 80);
      cyc(1'b1, p, o);
      exp_v[3] = (c >= 14 && c <= 70 && ((c - 14) % 8) == 0);
      exp_v[2] = (c == 70);
      exp_v[1] = (c >= 11 && c <= 81);
      exp_v[0] = 1'b0;
      checks++;
      if ({s_shift, s_bd, s_rcv, s_err} !== exp_v) begin
        errors++;
        $display("FAIL byte c=%0d got shift,bd,rcv,err=%b exp=%b", c, {s_shift, s_bd, s_rcv, s_err}, exp_v);
      end
      if (exp_v[3]) begin
        checks++;
        if (s_idx !== 3'((c - 14) / 8)) begin
          errors++;
          $display("FAIL byte_index c=%0d got=%0d exp=%0d", c, s_idx, (c - 14) / 8);
        end
      end
      if (c == 71) begin
        checks++;
        if (s_idx !== 3'd0) begin
          errors++;
          $display("FAIL byte_index_wrap got=%0d exp=0", s_idx);
        end
      end
    end
  endtask

  task automatic test_resync;
    logic p;
    logic [3:0] exp_v;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int r = 0; r <= 26; r++) begin
      p = (r == 0 || r == 6 || r == 10);
      cyc(r < 25, p, 1'b0);
      exp_v[3] = (r == 4 || r == 14 || r == 22);
      exp_v[2] = 1'b0;
      exp_v[1] = (r >= 1 && r <= 25);
      exp_v[0] = 1'b0;
      checks++;
      if ({s_shift, s_bd, s_rcv, s_err} !== exp_v) begin
        errors++;
        $display("FAIL resync r=%0d got shift,bd,rcv,err=%b exp=%b", r, {s_shift, s_bd, s_rcv, s_err}, exp_v);
      end
      if (r == 23) begin
        checks++;
        if (s_idx !== 3'd3) begin
          errors++;
          $display("FAIL resync_index got=%0d exp=3", s_idx);
        end
      end
    end
  endtask

  task automatic test_stuffing;
    logic p, o;
    logic [3:0] exp_v;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int r = 0; r <= 67; r++) begin
      p = (r == 0 || r == 8 || r == 62);
      o = (r == 63);
      cyc(r < 65, p, o);
      exp_v[3] = (r == 4) || (r >= 12 && r <= 60 && ((r - 12) % 8) == 0);
      exp_v[2] = (r == 60);
      exp_v[1] = (r >= 1 && r <= 60);
      exp_v[0] = (r >= 61 && r <= 65);
      checks++;
      if ({s_shift, s_bd, s_rcv, s_err} !== exp_v) begin
        errors++;
        $display("FAIL stuff r=%0d got shift,bd,rcv,err=%b exp=%b", r, {s_shift, s_bd, s_rcv, s_err}, exp_v);
      end
      if (r >= 61 && r <= 65) begin
        checks++;
        if (s_idx !== 3'd7) begin
          errors++;
          $display("FAIL stuff_index_frozen r=%0d got=%0d exp=7", r, s_idx);
        end
      end
    end
  endtask

  task automatic test_partial_eop;
    logic [3:0] exp_v;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int r = 0; r <= 34; r++) begin
      cyc(r < 32, r == 0, r == 28);
      exp_v[3] = (r == 4 || r == 12 || r == 20);
      exp_v[2] = 1'b0;
      exp_v[1] = (r >= 1 && r <= 28);
      exp_v[0] = (r >= 29 && r <= 32);
      checks++;
      if ({s_shift, s_bd, s_rcv, s_err} !== exp_v) begin
        errors++;
        $display("FAIL partial_eop r=%0d got shift,bd,rcv,err=%b exp=%b", r, {s_shift, s_bd, s_rcv, s_err}, exp_v);
      end
      if (r == 28) begin
        checks++;
        if (s_idx !== 3'd3) begin
          errors++;
          $display("FAIL partial_eop_index got=%0d exp=3", s_idx);
        end
      end
    end
  endtask

  task automatic test_abort;
    logic e, p;
    logic [3:0] exp_v;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int r = 0; r <= 48; r++) begin
      e = !(r >= 38 && r <= 40);
      p = (r == 0 || r == 24 || r == 42);
      cyc(e, p, 1'b0);
      exp_v[3] = (r == 4 || r == 12 || r == 20 || r == 28 || r == 36 || r == 46);
      exp_v[2] = 1'b0;
      exp_v[1] = (r >= 1 && r <= 38) || (r >= 43);
      exp_v[0] = 1'b0;
      checks++;
      if ({s_shift, s_bd, s_rcv, s_err} !== exp_v) begin
        errors++;
        $display("FAIL abort r=%0d got shift,bd,rcv,err=%b exp=%b", r, {s_shift, s_bd, s_rcv, s_err}, exp_v);
      end
      if (r == 37 || r == 46 || r == 47) begin
        checks++;
        if (s_idx !== ((r == 37) ? 3'd5 : (r == 46) ? 3'd0 : 3'd1)) begin
          errors++;
          $display("FAIL abort_index r=%0d got=%0d", r, s_idx);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      cyc(1'b1, 1'b0, 1'b0);
    end
    // bit_index is 1 here after the first shift; reset must clear it at once
    rst = 1'b1;
    #1;
    checks++;
    if ({rcving, shift_en, bit_index} !== 5'd0) begin
      errors++;
      $display("FAIL reset_async got rcving,shift,idx=%b exp=%b", {rcving, shift_en, bit_index}, 5'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < 10; r++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if ({s_shift, s_rcv} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_release r=%0d got shift,rcv=%b exp=00", r, {s_shift, s_rcv});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_resync();
    test_stuffing();
    test_partial_eop();
    test_abort();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
